// File: rtl/jesd_pkg.sv
// Shared definitions for the JESD204B-style link layer: control characters,
// link state encoding and initial-lane-alignment geometry.
package jesd_pkg;

    localparam logic [7:0] K_CHAR = 8'hBC;
    localparam logic [7:0] R_CHAR = 8'h1C;
    localparam logic [7:0] A_CHAR = 8'h7C;
    localparam logic [7:0] Q_CHAR = 8'h9C;

    // Encoding is shared with the transmitter's data_ctrl state.
    typedef enum logic [2:0] {
        ST_CGS  = 3'b001,
        ST_ILA  = 3'b010,
        ST_DATA = 3'b100
    } link_state_e;

    localparam int ILA_MF_NUM     = 4;
    localparam int ILA_CFG_OCTETS = 14;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = 8'hFF;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/jesd_rx_char_detect.sv
// Combinational decode of a received 8b/10b character into the link-layer
// control characters of interest.
module jesd_rx_char_detect
    import jesd_pkg::*;
(
    input  logic [7:0] rx_data,
    input  logic       rx_is_k,
    output logic       is_k,
    output logic       is_r,
    output logic       is_a,
    output logic       is_q
);

    assign is_k = rx_is_k && (rx_data == K_CHAR);
    assign is_r = rx_is_k && (rx_data == R_CHAR);
    assign is_a = rx_is_k && (rx_data == A_CHAR);
    assign is_q = rx_is_k && (rx_data == Q_CHAR);

endmodule

// File: rtl/jesd_rx_link_sync.sv
// Receiver link synchronizer: code-group sync, ILA multiframe validation with
// configuration capture, and user-data pass-through.
module jesd_rx_link_sync
    import jesd_pkg::*;
#(
    parameter int K       = 32,
    parameter int F       = 1,
    parameter int CGS_MIN = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_is_k,
    input  logic         rx_valid,
    output logic         sync,
    output logic [2:0]   link_state,
    output logic [1:0]   ila_mf,
    output logic [111:0] ila_cfg,
    output logic         cfg_valid,
    output logic [7:0]   data_out,
    output logic         data_out_valid,
    output logic         err,
    output logic [7:0]   err_cnt
);

    localparam int OCT_W  = $clog2(K * F);
    localparam int KCNT_W = $clog2(CGS_MIN + 1);
    localparam logic [OCT_W-1:0]  OCT_LAST  = OCT_W'(K * F - 1);
    localparam logic [KCNT_W-1:0] KCNT_LAST = KCNT_W'(CGS_MIN - 1);
    localparam logic [1:0]        MF_LAST   = 2'(ILA_MF_NUM - 1);

    logic is_k, is_r, is_a, is_q;

    link_state_e       state, state_nxt;
    logic [KCNT_W-1:0] kcnt, kcnt_nxt;
    logic [OCT_W-1:0]  oct, oct_nxt;
    logic [1:0]        mf_nxt;
    logic              wait_r, wait_nxt;
    logic              cfg_valid_nxt, sync_nxt, dov_nxt, err_nxt, proto_err;
    logic [111:0]      cfg_nxt;
    logic [7:0]        dout_nxt, err_cnt_nxt;

    jesd_rx_char_detect u_char_detect (
        .rx_data (rx_data),
        .rx_is_k (rx_is_k),
        .is_k    (is_k),
        .is_r    (is_r),
        .is_a    (is_a),
        .is_q    (is_q)
    );

    assign link_state = state;

    // Next-state, counter and capture logic; a protocol error overrides every advance.
    always_comb begin
        state_nxt     = state;
        kcnt_nxt      = kcnt;
        oct_nxt       = oct;
        mf_nxt        = ila_mf;
        wait_nxt      = wait_r;
        cfg_valid_nxt = cfg_valid;
        cfg_nxt       = ila_cfg;
        sync_nxt      = sync;
        dout_nxt      = data_out;
        dov_nxt       = 1'b0;
        err_nxt       = 1'b0;
        err_cnt_nxt   = err_cnt;
        proto_err     = 1'b0;

        if (rx_valid) begin
            case (state)
                ST_CGS: begin
                    sync_nxt = 1'b0;
                    if (!is_k) begin
                        kcnt_nxt = '0;
                    end else if (kcnt == KCNT_LAST) begin
                        state_nxt = ST_ILA;
                        sync_nxt  = 1'b1;
                        wait_nxt  = 1'b1;
                        kcnt_nxt  = '0;
                    end else begin
                        kcnt_nxt = kcnt + KCNT_W'(1);
                    end
                end
                ST_ILA: begin
                    if (wait_r) begin
                        // The /R/ that ends the wait is octet 0 of multiframe 0.
                        if (is_r) begin
                            wait_nxt = 1'b0;
                            oct_nxt  = OCT_W'(1);
                            mf_nxt   = 2'd0;
                        end else if (is_k) begin
                            wait_nxt = 1'b1;
                        end else begin
                            proto_err = 1'b1;
                        end
                    end else begin
                        if (oct == '0) begin
                            proto_err = !is_r;
                        end else if (oct == OCT_LAST) begin
                            proto_err = !is_a;
                        end else if (is_r || is_a) begin
                            proto_err = 1'b1;
                        end else if ((ila_mf == 2'd1) && (oct == OCT_W'(1))) begin
                            proto_err = !is_q;
                        end else begin
                            proto_err = 1'b0;
                        end

                        for (int n = 0; n < ILA_CFG_OCTETS; n++) begin
                            if ((ila_mf == 2'd1) && (oct == OCT_W'(n + 2))) begin
                                cfg_nxt[8*n +: 8] = rx_data;
                            end else begin
                                cfg_nxt[8*n +: 8] = ila_cfg[8*n +: 8];
                            end
                        end

                        if (oct == OCT_LAST) begin
                            oct_nxt = '0;
                            if (ila_mf == 2'd1) begin
                                cfg_valid_nxt = 1'b1;
                            end else begin
                                cfg_valid_nxt = cfg_valid;
                            end
                            if (ila_mf == MF_LAST) begin
                                state_nxt = ST_DATA;
                            end else begin
                                mf_nxt = ila_mf + 2'd1;
                            end
                        end else begin
                            oct_nxt = oct + OCT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    dout_nxt = rx_data;
                    dov_nxt  = 1'b1;
                    if (!is_k) begin
                        kcnt_nxt = '0;
                    end else if (kcnt == KCNT_LAST) begin
                        proto_err = 1'b1;
                    end else begin
                        kcnt_nxt = kcnt + KCNT_W'(1);
                    end
                end
                default: begin
                    proto_err = 1'b1;
                end
            endcase

            if (proto_err) begin
                state_nxt     = ST_CGS;
                sync_nxt      = 1'b0;
                kcnt_nxt      = '0;
                oct_nxt       = '0;
                mf_nxt        = 2'd0;
                wait_nxt      = 1'b0;
                cfg_valid_nxt = 1'b0;
                cfg_nxt       = ila_cfg;
                dout_nxt      = data_out;
                dov_nxt       = 1'b0;
                err_nxt       = 1'b1;
                err_cnt_nxt   = sat_inc8(err_cnt);
            end else begin
                err_nxt = 1'b0;
            end
        end else begin
            dov_nxt = 1'b0;
            err_nxt = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_CGS;
            kcnt           <= '0;
            oct            <= '0;
            ila_mf         <= 2'd0;
            wait_r         <= 1'b0;
            cfg_valid      <= 1'b0;
            ila_cfg        <= 112'd0;
            sync           <= 1'b0;
            data_out       <= 8'd0;
            data_out_valid <= 1'b0;
            err            <= 1'b0;
            err_cnt        <= 8'd0;
        end else begin
            state          <= state_nxt;
            kcnt           <= kcnt_nxt;
            oct            <= oct_nxt;
            ila_mf         <= mf_nxt;
            wait_r         <= wait_nxt;
            cfg_valid      <= cfg_valid_nxt;
            ila_cfg        <= cfg_nxt;
            sync           <= sync_nxt;
            data_out       <= dout_nxt;
            data_out_valid <= dov_nxt;
            err            <= err_nxt;
            err_cnt        <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_jesd_rx_link_sync.sv
// Directed, table-driven bench for jesd_rx_link_sync (K=32, F=1, CGS_MIN=4).
module tb_jesd_rx_link_sync;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_is_k;
    logic         rx_valid;
    logic         sync;
    logic [2:0]   link_state;
    logic [1:0]   ila_mf;
    logic [111:0] ila_cfg;
    logic         cfg_valid;
    logic [7:0]   data_out;
    logic         data_out_valid;
    logic         err;
    logic [7:0]   err_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [111:0] EXP_CFG = 112'h0E0D0C0B0A090807060504030201;

    typedef struct {
        logic [7:0] d;
        logic       k;
        logic [2:0] exp_state;
        logic       exp_sync;
        logic       exp_err;
    } vec_t;

    vec_t cgs_tab[8];
    vec_t res_tab[4];

    jesd_rx_link_sync #(.K(32), .F(1), .CGS_MIN(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_is_k        (rx_is_k),
        .rx_valid       (rx_valid),
        .sync           (sync),
        .link_state     (link_state),
        .ila_mf         (ila_mf),
        .ila_cfg        (ila_cfg),
        .cfg_valid      (cfg_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .err            (err),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic k, input logic v);
        rx_data  = d;
        rx_is_k  = k;
        rx_valid = v;
        @(posedge clk);
        #1;
    endtask

    // ILA character at multiframe m, octet p as {is_k, data}.
    function automatic logic [8:0] ila_char(input int m, input int p);
        logic [8:0] c;
        if (p == 0) c = {1'b1, 8'h1C};
        else if (p == 31) c = {1'b1, 8'h7C};
        else if (m == 1 && p == 1) c = {1'b1, 8'h9C};
        else if (m == 1 && p <= 15) c = {1'b0, 8'(p - 1)};
        else c = {1'b0, 8'(m * 40 + p)};
        return c;
    endfunction

    task automatic send_ila(input int m, input int from, input int upto);
        logic [8:0] c;
        for (int p = from; p < upto; p++) begin
            c = ila_char(m, p);
            step(c[7:0], c[8], 1'b1);
        end
    endtask

    task automatic send_k(input int n);
        for (int i = 0; i < n; i++) step(8'hBC, 1'b1, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sync"}, sync, 1'b0);
        chk({tag, "_state"}, link_state, 3'b001);
        chk({tag, "_mf"}, ila_mf, 2'd0);
        chk({tag, "_cfg"}, ila_cfg, 112'd0);
        chk({tag, "_cfg_valid"}, cfg_valid, 1'b0);
        chk({tag, "_dout"}, data_out, 8'd0);
        chk({tag, "_dov"}, data_out_valid, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_err_cnt"}, err_cnt, 8'd0);
    endtask

    initial begin
        cgs_tab[0] = '{8'hBC, 1'b1, 3'b001, 1'b0, 1'b0};
        cgs_tab[1] = '{8'hBC, 1'b1, 3'b001, 1'b0, 1'b0};
        cgs_tab[2] = '{8'hBC, 1'b1, 3'b001, 1'b0, 1'b0};
        cgs_tab[3] = '{8'h55, 1'b0, 3'b001, 1'b0, 1'b0};
        cgs_tab[4] = '{8'hBC, 1'b1, 3'b001, 1'b0, 1'b0};
        cgs_tab[5] = '{8'hBC, 1'b1, 3'b001, 1'b0, 1'b0};
        cgs_tab[6] = '{8'hBC, 1'b1, 3'b001, 1'b0, 1'b0};
        cgs_tab[7] = '{8'hBC, 1'b1, 3'b010, 1'b1, 1'b0};
        res_tab[0] = '{8'hBC, 1'b1, 3'b100, 1'b1, 1'b0};
        res_tab[1] = '{8'hBC, 1'b1, 3'b100, 1'b1, 1'b0};
        res_tab[2] = '{8'hBC, 1'b1, 3'b100, 1'b1, 1'b0};
        res_tab[3] = '{8'hBC, 1'b1, 3'b001, 1'b0, 1'b1};

        rst = 1'b1;
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        chk_reset_vals("reset");
        rst = 1'b0;

        // CGS entry
        for (int i = 0; i < 8; i++) begin
            step(cgs_tab[i].d, cgs_tab[i].k, 1'b1);
            chk($sformatf("cgs%0d_state", i), link_state, cgs_tab[i].exp_state);
            chk($sformatf("cgs%0d_sync", i), sync, cgs_tab[i].exp_sync);
            chk($sformatf("cgs%0d_err", i), err, cgs_tab[i].exp_err);
        end
        send_k(2);
        chk("wait_k_state", link_state, 3'b010);
        chk("wait_k_err", err, 1'b0);

        // Full ILA with a 5-cycle stall in multiframe 2
        send_ila(0, 0, 32);
        chk("mf0_end_mf", ila_mf, 2'd1);
        send_ila(1, 0, 31);
        chk("mf1_pre_cfg_valid", cfg_valid, 1'b0);
        send_ila(1, 31, 32);
        chk("mf1_cfg_valid", cfg_valid, 1'b1);
        chk("mf1_cfg", ila_cfg, EXP_CFG);
        chk("mf1_end_mf", ila_mf, 2'd2);
        send_ila(2, 0, 10);
        for (int i = 0; i < 5; i++) begin
            step(8'h7C, 1'b1, 1'b0);
            chk($sformatf("stall%0d_err", i), err, 1'b0);
        end
        chk("stall_mf", ila_mf, 2'd2);
        chk("stall_state", link_state, 3'b010);
        send_ila(2, 10, 32);
        chk("mf2_end_err", err_cnt, 8'd0);
        chk("mf2_end_mf", ila_mf, 2'd3);
        send_ila(3, 0, 31);
        chk("pre_final_state", link_state, 3'b010);
        send_ila(3, 31, 32);
        chk("data_state", link_state, 3'b100);
        chk("data_dov0", data_out_valid, 1'b0);
        step(8'hA5, 1'b0, 1'b1);
        chk("data_a5", data_out, 8'hA5);
        chk("data_a5_dov", data_out_valid, 1'b1);
        step(8'h3C, 1'b0, 1'b1);
        chk("data_3c", data_out, 8'h3C);
        step(8'h77, 1'b0, 1'b0);
        chk("data_stall_dov", data_out_valid, 1'b0);
        chk("data_stall_dout", data_out, 8'h3C);

        // DATA resync on 4 consecutive /K/
        for (int i = 0; i < 4; i++) begin
            step(res_tab[i].d, res_tab[i].k, 1'b1);
            chk($sformatf("res%0d_state", i), link_state, res_tab[i].exp_state);
            chk($sformatf("res%0d_sync", i), sync, res_tab[i].exp_sync);
            chk($sformatf("res%0d_err", i), err, res_tab[i].exp_err);
        end
        chk("res_err_cnt", err_cnt, 8'd1);
        chk("res_cfg_valid", cfg_valid, 1'b0);

        // The /K/ on the error cycle must not count: 3 more stay in CGS
        send_k(3);
        chk("post_err_k3_state", link_state, 3'b010 ^ 3'b011);
        chk("post_err_k3_err", err, 1'b0);
        send_k(1);
        chk("post_err_k4_state", link_state, 3'b010);

        // Misplaced /A/ at octet 20 of multiframe 2
        send_ila(0, 0, 32);
        send_ila(1, 0, 32);
        send_ila(2, 0, 20);
        chk("misA_pre_err", err, 1'b0);
        step(8'h7C, 1'b1, 1'b1);
        chk("misA_err", err, 1'b1);
        chk("misA_err_cnt", err_cnt, 8'd2);
        chk("misA_sync", sync, 1'b0);
        chk("misA_state", link_state, 3'b001);
        chk("misA_cfg_valid", cfg_valid, 1'b0);
        chk("misA_cfg", ila_cfg, EXP_CFG);
        chk("misA_mf", ila_mf, 2'd0);
        step(8'h00, 1'b0, 1'b1);
        chk("misA_pulse", err, 1'b0);

        // Missing /Q/ at octet 1 of multiframe 1
        send_k(4);
        send_ila(0, 0, 32);
        send_ila(1, 0, 1);
        step(8'h00, 1'b0, 1'b1);
        chk("noQ_err", err, 1'b1);
        chk("noQ_state", link_state, 3'b001);
        chk("noQ_err_cnt", err_cnt, 8'd3);

        // Error counter saturation via bad character while waiting for /R/
        for (int i = 0; i < 260; i++) begin
            send_k(4);
            step(8'h00, 1'b0, 1'b1);
        end
        chk("sat_err_cnt", err_cnt, 8'hFF);
        chk("sat_err", err, 1'b1);

        // Reset mid-DATA
        send_k(4);
        for (int m = 0; m < 4; m++) send_ila(m, 0, 32);
        step(8'hA5, 1'b0, 1'b1);
        chk("rst_pre_state", link_state, 3'b100);
        chk("rst_pre_dout", data_out, 8'hA5);
        rst = 1'b1;
        step(8'hBC, 1'b1, 1'b1);
        rst = 1'b0;
        chk_reset_vals("rst_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jesd_rx_link_sync.md
# jesd_rx_link_sync

Receiver-side link-layer synchronizer for the JESD204B-style lane whose transmitter sequences CGS → ILA → DATA under control of `sync`. It consumes decoded 8b/10b characters and drives the active-low `sync` request back to the transmitter. It tracks code-group synchronization and validates the four initial-lane-alignment multiframes, capturing the 14 link-configuration octets. Once alignment is confirmed, it passes user data through.

## Interface
- `K` — default 32 — frames per multiframe.
- `F` — default 1 — octets per frame. Constraint: `K*F` ≥ 17 and `K*F` ≤ 256.
- `CGS_MIN` — default 4 — consecutive /K/ characters required to finish CGS.
- `clk` — in, 1 — single clock.
- `rst` — in, 1 — reset. Synchronous, active-high.
- `rx_data` — in, 8 — decoded character.
- `rx_is_k` — in, 1 — `rx_data` is a control character.
- `rx_valid` — in, 1 — character qualifier. When low, all state, counters and outputs hold, except `err` and `data_out_valid`, which read 0.
- `sync` — out, 1 — synchronization request to the transmitter. 0 = request resync.
- `link_state` — out, 3 — one-hot state: 3'b001 CGS, 3'b010 ILA, 3'b100 DATA.
- `ila_mf` — out, 2 — index of the current ILA multiframe, 0..3.
- `ila_cfg` — out, 112 — configuration octets; octet n occupies bits [8n+7:8n].
- `cfg_valid` — out, 1 — `ila_cfg` is complete and stable.
- `data_out` — out, 8 — user data.
- `data_out_valid` — out, 1 — qualifier for `data_out`.
- `err` — out, 1 — one-cycle pulse when a protocol error forces a resync.
- `err_cnt` — out, 8 — count of errors; saturates at 255.

## Operation
The descriptions below apply only to cycles where `rx_valid` = 1. Character codes:
- /K/ = K28.5 = 0xBC, with `rx_is_k` = 1.
- /R/ = 0x1C, with `rx_is_k` = 1.
- /A/ = 0x7C, with `rx_is_k` = 1.
- /Q/ = 0x9C, with `rx_is_k` = 1.

**CGS state**
- `sync` = 0.
- `kcnt` increments on each /K/ and clears on any other character.
- When the `CGS_MIN`-th consecutive /K/ is sampled, the block moves to ILA, sets `sync` = 1 and sets `wait_r` = 1.

**ILA state, while `wait_r` = 1**
- /K/ is accepted and does nothing.
- /R/ clears `wait_r`, sets `oct` = 1 and sets `ila_mf` = 0.
- Any other character is an error.

**ILA state, while `wait_r` = 0**
- `oct` counts 0..`K*F`-1 and wraps.
- At `oct` = 0, the character must be /R/.
- At `oct` = `K*F`-1, the character must be /A/.
- At any other position, /R/ or /A/ is an error. Other characters are accepted.
- In multiframe 1:
  - `oct` = 1 must be /Q/.
  - `oct` = 2..15 are written to `ila_cfg` octets 0..13.
- When /A/ is sampled at the end of multiframe 1, `cfg_valid` is set.
- When /A/ is sampled at the end of multiframe 3, the block moves to DATA. Otherwise `ila_mf` increments.

**DATA state**
- Each character is registered to `data_out` with `data_out_valid` = 1.
- `kcnt` counts consecutive /K/. Reaching `CGS_MIN` is an error.

**Error, from any state**
- `err` pulses.
- `err_cnt` increments.
- The block returns to CGS with `sync` = 0.
- `kcnt`, `oct`, `ila_mf`, `wait_r` and `cfg_valid` clear.
- `ila_cfg` is retained.
- A /K/ on the error cycle does not count toward the new CGS.

## Timing
- All outputs are registered.
- Values after reset:
  - `sync` = 0
  - `link_state` = 3'b001
  - `ila_mf` = 0
  - `ila_cfg` = 0
  - `cfg_valid` = 0
  - `data_out` = 0
  - `data_out_valid` = 0
  - `err` = 0
  - `err_cnt` = 0
- `rst` asserted in any state: the next edge puts the block in CGS with the reset values above. No error is counted.
- `sync` rises on the same edge that `link_state` becomes ILA, which is the edge sampling the `CGS_MIN`-th /K/.
- `sync` falls on the edge following a sampled error.
- Data latency is 1 cycle from `rx_data` to `data_out`. The first data character is the one sampled on the cycle after the final /A/.
- `cfg_valid` rises on the edge that samples /A/ at the end of multiframe 1.
- Simultaneous events: an error check takes priority over every advance, including the final /A/ of multiframe 3.

## Structure
- Shared package `jesd_pkg` holds:
  - the character codes `K_CHAR`, `R_CHAR`, `A_CHAR`, `Q_CHAR`;
  - the one-hot state encodings `ST_CGS`, `ST_ILA`, `ST_DATA`, which must match the transmitter's `data_ctrl` encoding;
  - `ILA_MF_NUM` = 4;
  - `ILA_CFG_OCTETS` = 14.
- One sub-module, `jesd_rx_char_detect`, performs the combinational decode of `rx_data`/`rx_is_k` into the flags `is_k`, `is_r`, `is_a`, `is_q`.
- The FSM, the `kcnt`/`oct`/`ila_mf` counters and the capture registers live in the top module.

## Test plan
Parameters for all scenarios: `K` = 32, `F` = 1, `CGS_MIN` = 4.
- **CGS entry.** Stimulus: reset, then 3×/K/, 0x55, 4×/K/. Required: `sync` stays 0 through the 0x55; it rises at the 8th character's edge; `link_state` = 3'b010.
- **Full ILA.** Stimulus: 2 extra /K/, then four multiframes. Each is /R/…/A/, 32 octets long, with multiframe 1 containing /Q/ at position 1 and config bytes 0x01..0x0E. Required:
  - `cfg_valid` = 1 and `ila_cfg` = 0x0E0D…0201;
  - `link_state` = 3'b100 after the 128th ILA octet;
  - the next input 0xA5 appears on `data_out` one cycle later.
- **Misplaced /A/.** Stimulus: /A/ at `oct` = 20 of multiframe 2. Required: one-cycle `err`, `err_cnt` = 1, `sync` = 0 next edge, `cfg_valid` = 0, `ila_cfg` retained.
- **Missing /Q/.** Stimulus: multiframe 1 `oct` = 1 = 0x00. Required: `err` pulses, state returns to CGS.
- **DATA resync.** Stimulus: in DATA, 4×/K/. Required: `err` on the 4th; `sync` = 0, `link_state` = 3'b001.
- **Stall and reset.** Stimulus: `rx_valid` low for 5 cycles mid-ILA. Required: `oct` and `ila_mf` hold. Then stimulus: `rst` mid-DATA. Required: all reset values, with `err_cnt` = 0.
